mem_port_arbiter: RTL and testbench

Parametrised multi-port front end to the single memory backend controller. It accepts read and masked-write requests from `PORTS` independent clients, such as instruction fetch and load/store units. Requests are queued one per port and arbitrated round-robin or by fixed priority onto a single-outstanding backend request/response channel. Each port sees a level `busy` and a one-cycle `done` pulse, plus read data that stays stable between transactions.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and arbitration-mode constants
// for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: selects one pending requester, either round-robin from a
// rotating pointer or fixed lowest-index-first.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  N    = 2,
    parameter int  MODE = ARB_RR,
    localparam int IW   = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  pend,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    logic [IW-1:0] ptr;

    // Descending scan so the last hit, i.e. the first in search order, wins.
    always_comb begin
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (MODE == ARB_FIXED) ? k : (int'(ptr) + k) % N;
            if (pend[j]) grant_idx = IW'(j);
        end
        any   = |pend;
        grant = any ? N'(1) << grant_idx : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ptr <= '0;
        else if (advance) ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: holds one read/masked-write request per client port and
// serialises them onto a single-outstanding memory backend channel.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int PORTS    = 2,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    parameter int MASK_W   = LINE_W / 8,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [PORTS-1:0]           req_valid,
    input  logic [PORTS-1:0]           req_write,
    input  logic [PORTS*ADDR_W-1:0]    req_addr,
    input  logic [PORTS*LINE_W-1:0]    req_wdata,
    input  logic [PORTS*MASK_W-1:0]    req_mask,
    output logic [PORTS*LINE_W-1:0]    rsp_rdata,
    output logic [PORTS-1:0]           busy,
    output logic [PORTS-1:0]           done,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_write,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [LINE_W-1:0]          mem_req_wdata,
    output logic [MASK_W-1:0]          mem_req_mask,
    input  logic                       mem_rsp_valid,
    input  logic [LINE_W-1:0]          mem_rsp_rdata
);
    localparam int IW = $clog2(PORTS);

    state_t            state;
    logic [IW-1:0]     g;
    logic [IW-1:0]     grant_idx;
    logic [PORTS-1:0]  pend, grant, cap, fin, wr_q;
    logic              any;
    logic [ADDR_W-1:0] addr_q  [PORTS];
    logic [LINE_W-1:0] wdata_q [PORTS];
    logic [MASK_W-1:0] mask_q  [PORTS];
    logic [LINE_W-1:0] rdata_q [PORTS];

    assign cap = req_valid & ~busy;
    assign fin = (state == WAIT && mem_rsp_valid) ? PORTS'(1) << g : '0;

    rr_arbiter #(.N(PORTS), .MODE(ARB_MODE)) u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .pend      (pend),
        .advance   (state == IDLE && any),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign rsp_rdata[i*LINE_W +: LINE_W] = rdata_q[i];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            g             <= '0;
            pend          <= '0;
            busy          <= '0;
            done          <= '0;
            wr_q          <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_mask  <= '0;
            for (int i = 0; i < PORTS; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                mask_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            pend <= (pend & ~((state == IDLE) ? grant : '0)) | cap;
            busy <= (busy | cap) & ~fin;
            done <= fin;
            for (int i = 0; i < PORTS; i++) begin
                if (cap[i]) begin
                    wr_q[i]    <= req_write[i];
                    addr_q[i]  <= req_addr[i*ADDR_W +: ADDR_W];
                    wdata_q[i] <= req_wdata[i*LINE_W +: LINE_W];
                    mask_q[i]  <= req_mask[i*MASK_W +: MASK_W];
                end
            end
            case (state)
                IDLE: if (any) begin
                    g             <= grant_idx;
                    mem_req_valid <= 1'b1;
                    mem_req_write <= wr_q[grant_idx];
                    mem_req_addr  <= addr_q[grant_idx];
                    mem_req_wdata <= wdata_q[grant_idx];
                    mem_req_mask  <= wr_q[grant_idx] ? mask_q[grant_idx] : '0;
                    state         <= ISSUE;
                end
                ISSUE: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= WAIT;
                end
                // Backend fields stay held after acceptance, so mem_req_write still names the op.
                WAIT: if (mem_rsp_valid) begin
                    if (!mem_req_write) rdata_q[g] <= mem_rsp_rdata;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors and randomized traffic against a
// transaction-level model, for both round-robin and fixed-priority builds.
module tb_mem_port_arbiter;
    localparam int P  = 3;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [P-1:0]    req_valid = '0, req_write = '0;
    logic [P*AW-1:0] req_addr = '0;
    logic [P*LW-1:0] req_wdata = '0;
    logic [P*MW-1:0] req_mask = '0;
    logic            mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [LW-1:0]   mem_rsp_rdata = '0;

    logic [P*LW-1:0] rr_rdata, fx_rdata, o_rdata;
    logic [P-1:0]    rr_busy, fx_busy, o_busy, rr_done, fx_done, o_done;
    logic            rr_valid, fx_valid, o_valid, rr_write, fx_write, o_write;
    logic [AW-1:0]   rr_addr, fx_addr, o_addr;
    logic [LW-1:0]   rr_wdata, fx_wdata, o_wdata;
    logic [MW-1:0]   rr_mask, fx_mask, o_mask;

    bit sel = 1'b0;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.PORTS(P), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(0)) dut_rr (
        .CLK(clk), .RST(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_rdata(rr_rdata), .busy(rr_busy), .done(rr_done),
        .mem_req_valid(rr_valid), .mem_req_ready(mem_req_ready), .mem_req_write(rr_write),
        .mem_req_addr(rr_addr), .mem_req_wdata(rr_wdata), .mem_req_mask(rr_mask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata));

    mem_port_arbiter #(.PORTS(P), .ADDR_W(AW), .LINE_W(LW), .ARB_MODE(1)) dut_fx (
        .CLK(clk), .RST(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_rdata(fx_rdata), .busy(fx_busy), .done(fx_done),
        .mem_req_valid(fx_valid), .mem_req_ready(mem_req_ready), .mem_req_write(fx_write),
        .mem_req_addr(fx_addr), .mem_req_wdata(fx_wdata), .mem_req_mask(fx_mask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata));

    assign o_rdata = sel ? fx_rdata : rr_rdata;
    assign o_busy  = sel ? fx_busy  : rr_busy;
    assign o_done  = sel ? fx_done  : rr_done;
    assign o_valid = sel ? fx_valid : rr_valid;
    assign o_write = sel ? fx_write : rr_write;
    assign o_addr  = sel ? fx_addr  : rr_addr;
    assign o_wdata = sel ? fx_wdata : rr_wdata;
    assign o_mask  = sel ? fx_mask  : rr_mask;

    // Transaction-level model: captured requests, the one transaction in flight, last winner.
    logic [P-1:0]  busy_m, pend_m, done_m;
    bit            m_wr [P];
    logic [AW-1:0] m_addr [P];
    logic [LW-1:0] m_wdata [P];
    logic [MW-1:0] m_mask [P];
    logic [LW-1:0] rdata_m [P];
    bit            issued_m, waiting_m, idle_m, e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    logic [MW-1:0] e_mask;
    int            cur, last, dly;

    task automatic check(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < P; k++) begin
            int j;
            j = sel ? k : (last + 1 + k) % P;
            if (pend_m[j]) return j;
        end
        return 0;
    endfunction

    task automatic set_req(int p, bit wr, logic [AW-1:0] a, logic [LW-1:0] d, logic [MW-1:0] m);
        req_write[p]          = wr;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*LW +: LW] = d;
        req_mask[p*MW +: MW]  = m;
    endtask

    task automatic do_reset(bit s);
        req_valid     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        sel           = s;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", LW'(o_busy), '0);
        check("rst_done", LW'(o_done), '0);
        check("rst_valid", LW'(o_valid), '0);
        check("rst_write", LW'(o_write), '0);
        check("rst_addr", LW'(o_addr), '0);
        check("rst_wdata", o_wdata, '0);
        check("rst_mask", LW'(o_mask), '0);
        for (int i = 0; i < P; i++) check("rst_rdata", o_rdata[i*LW +: LW], '0);
        @(negedge clk);
        rst_n    = 1'b1;
        busy_m   = '0;
        pend_m   = '0;
        done_m   = '0;
        issued_m = 1'b0;
        waiting_m = 1'b0;
        idle_m   = 1'b1;
        last     = P - 1;
        for (int i = 0; i < P; i++) rdata_m[i] = '0;
    endtask

    task automatic step();
        logic [P-1:0] cap;
        bit completed;
        @(posedge clk);
        cap       = req_valid & ~busy_m;
        completed = 1'b0;
        done_m    = '0;
        if (issued_m && mem_req_ready) begin
            issued_m  = 1'b0;
            waiting_m = 1'b1;
            dly       = $urandom_range(0, 3);
        end else if (waiting_m && mem_rsp_valid) begin
            waiting_m    = 1'b0;
            completed    = 1'b1;
            done_m[cur]  = 1'b1;
            busy_m[cur]  = 1'b0;
            if (!e_wr) rdata_m[cur] = mem_rsp_rdata;
        end else if (idle_m && pend_m != '0) begin
            cur         = pick();
            last        = cur;
            pend_m[cur] = 1'b0;
            issued_m    = 1'b1;
            e_wr        = m_wr[cur];
            e_addr      = m_addr[cur];
            e_wdata     = m_wdata[cur];
            e_mask      = m_mask[cur];
        end
        for (int i = 0; i < P; i++) begin
            if (cap[i]) begin
                pend_m[i]  = 1'b1;
                busy_m[i]  = 1'b1;
                m_wr[i]    = req_write[i];
                m_addr[i]  = req_addr[i*AW +: AW];
                m_wdata[i] = req_wdata[i*LW +: LW];
                m_mask[i]  = req_mask[i*MW +: MW];
            end
        end
        idle_m = !issued_m && !waiting_m && !completed;
        @(negedge clk);
        check("busy", LW'(o_busy), LW'(busy_m));
        check("done", LW'(o_done), LW'(done_m));
        check("req_valid", LW'(o_valid), LW'(issued_m));
        if (issued_m) begin
            check("req_write", LW'(o_write), LW'(e_wr));
            check("req_addr", LW'(o_addr), LW'(e_addr));
            check("req_wdata", o_wdata, e_wdata);
            check("req_mask", LW'(o_mask), e_wr ? LW'(e_mask) : '0);
        end
        for (int i = 0; i < P; i++) check("rdata", o_rdata[i*LW +: LW], rdata_m[i]);
    endtask

    task automatic auto_backend();
        mem_req_ready = $urandom_range(0, 3) != 0;
        if (waiting_m) begin
            mem_rsp_valid = (dly == 0);
            if (dly > 0) dly--;
        end else mem_rsp_valid = $urandom_range(0, 9) == 0;
        mem_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    typedef struct {
        int            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        int            rdy;
        int            rsp;
        logic [LW-1:0] data;
        int            lat;
        logic [MW-1:0] exp_mask;
        logic [LW-1:0] exp_rdata;
    } vec_t;

    localparam logic [LW-1:0] D0 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    localparam logic [LW-1:0] D1 = 128'h11112222_33334444_55556666_77778888;

    initial begin
        vec_t vecs [5];
        vec_t v;
        int   lat, vcnt, wcnt;
        bit   got;
        int   order [$];

        vecs[0] = '{0, 1'b0, 32'h100, 16'hFFFF, 0, 0, D0, 4, 16'h0000, D0};
        vecs[1] = '{1, 1'b1, 32'h200, 16'h000F, 0, 0, D1, 4, 16'h000F, '0};
        vecs[2] = '{2, 1'b0, 32'h300, 16'h1234, 5, 0, D1, 9, 16'h0000, D1};
        vecs[3] = '{1, 1'b0, 32'h340, 16'h00FF, 2, 3, D0, 9, 16'h0000, D0};
        vecs[4] = '{0, 1'b1, 32'h480, 16'hA5A5, 1, 1, D0, 6, 16'hA5A5, '0};

        for (int r = 0; r < 5; r++) begin
            v = vecs[r];
            do_reset(1'b0);
            set_req(v.port, v.wr, v.addr, {4{32'h5A5A_0F0F}}, v.mask);
            req_valid         = '0;
            req_valid[v.port] = 1'b1;
            mem_rsp_rdata     = v.data;
            lat  = 0;
            vcnt = 0;
            wcnt = 0;
            got  = 1'b0;
            while (lat < 40 && !got) begin
                step();
                lat++;
                req_valid = '0;
                if (o_valid) begin
                    if (vcnt == 0) begin
                        check("vec_mask", LW'(o_mask), LW'(v.exp_mask));
                        check("vec_addr", LW'(o_addr), LW'(v.addr));
                    end
                    vcnt++;
                end
                if (waiting_m) wcnt++;
                mem_req_ready = o_valid && vcnt > v.rdy;
                mem_rsp_valid = waiting_m && wcnt > v.rsp;
                got = o_done[v.port];
            end
            check("vec_latency", LW'(lat), LW'(v.lat));
            check("vec_rdata", o_rdata[v.port*LW +: LW], v.exp_rdata);
        end

        // Round-robin contention: ports 0 and 1 keep re-requesting.
        do_reset(1'b0);
        set_req(0, 1'b0, 32'h1000, {4{32'hCAFE0000}}, 16'hFFFF);
        set_req(1, 1'b1, 32'h2000, {4{32'hBEEF0001}}, 16'h00FF);
        req_valid = 3'b011;
        order.delete();
        for (int c = 0; c < 200 && order.size() < 8; c++) begin
            auto_backend();
            step();
            if (o_done != '0) order.push_back(o_done[0] ? 0 : (o_done[1] ? 1 : 2));
        end
        check("rr_count", LW'(order.size()), LW'(8));
        foreach (order[k]) check("rr_order", LW'(order[k]), LW'(k % 2));

        // Fixed priority: port 0 re-requests on every done and starves port 1.
        do_reset(1'b1);
        req_valid = 3'b011;
        order.delete();
        for (int c = 0; c < 200 && order.size() < 6; c++) begin
            auto_backend();
            step();
            if (o_done != '0) order.push_back(o_done[0] ? 0 : (o_done[1] ? 1 : 2));
        end
        check("fx_count", LW'(order.size()), LW'(6));
        foreach (order[k]) check("fx_order", LW'(order[k]), '0);
        check("fx_starved_busy", LW'(o_busy[1]), LW'(1));

        // Reset while waiting for the backend, then a stale response arrives.
        do_reset(1'b0);
        set_req(0, 1'b0, 32'h400, '0, '0);
        req_valid     = 3'b001;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 10 && !waiting_m; c++) begin
            step();
            req_valid = '0;
        end
        check("reached_wait", LW'(waiting_m), LW'(1));
        do_reset(1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = '1;
        repeat (3) step();
        check("stale_rdata", o_rdata[LW-1:0], '0);
        mem_rsp_valid = 1'b0;

        // Randomized traffic in both arbitration modes.
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            for (int c = 0; c < 2500; c++) begin
                for (int p = 0; p < P; p++) begin
                    req_valid[p] = $urandom_range(0, 2) == 0;
                    set_req(p, 1'($urandom_range(0, 1)), $urandom, {4{$urandom}}, 16'($urandom));
                end
                auto_backend();
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
